// File: rtl/altr_hps_pd_seq_pkg.sv
// Shared types and constants for the power-domain sequencer.
//    state_t   : sequencer state encoding
//    outs_t    : bundle of the registered domain-control outputs (err is kept separately)
//    OFF_OUTS  : output values with the domain fully powered down and clamped
//    decode_outs() : state -> output bundle
//    is_timeout_wait() : states that wait on pwr_good and use the counter as a timeout
package altr_hps_pd_seq_pkg;

   typedef enum logic [3:0] {
      OFF,
      PWR_UP,
      CLK_ON,
      RST_REL,
      ISO_REL,
      ON,
      ISO_SET,
      RST_SET,
      CLK_OFF,
      PWR_DN
   } state_t;

   typedef struct packed {
      logic pwr_sw_en;
      logic clk_en;
      logic dom_rst_n;
      logic iso_en;
      logic pwr_ack;
      logic busy;
   } outs_t;

   localparam outs_t OFF_OUTS = '{
      pwr_sw_en: 1'b0,
      clk_en:    1'b0,
      dom_rst_n: 1'b0,
      iso_en:    1'b1,
      pwr_ack:   1'b0,
      busy:      1'b0
   };

   // Each step of the up sequence turns one more control on; the down
   // sequence undoes them in reverse order, so every state is OFF_OUTS
   // with a few fields overridden.
   function automatic outs_t decode_outs(input state_t st);
      outs_t o;
      o = OFF_OUTS;
      case (st)
         PWR_UP: begin
            o.pwr_sw_en = 1'b1;
            o.busy      = 1'b1;
         end
         CLK_ON, RST_SET: begin
            o.pwr_sw_en = 1'b1;
            o.clk_en    = 1'b1;
            o.busy      = 1'b1;
         end
         RST_REL, ISO_SET: begin
            o.pwr_sw_en = 1'b1;
            o.clk_en    = 1'b1;
            o.dom_rst_n = 1'b1;
            o.busy      = 1'b1;
         end
         ISO_REL: begin
            o.pwr_sw_en = 1'b1;
            o.clk_en    = 1'b1;
            o.dom_rst_n = 1'b1;
            o.iso_en    = 1'b0;
            o.busy      = 1'b1;
         end
         ON: begin
            o.pwr_sw_en = 1'b1;
            o.clk_en    = 1'b1;
            o.dom_rst_n = 1'b1;
            o.iso_en    = 1'b0;
            o.pwr_ack   = 1'b1;
         end
         CLK_OFF: begin
            o.pwr_sw_en = 1'b1;
            o.busy      = 1'b1;
         end
         PWR_DN: begin
            o.busy      = 1'b1;
         end
         default: o = OFF_OUTS;
      endcase
      return o;
   endfunction

   function automatic logic is_timeout_wait(input state_t st);
      return (st == PWR_UP) || (st == PWR_DN);
   endfunction

endpackage

// File: rtl/altr_hps_pd_seq_if.sv
// Bundle of the power-domain request/status and control signals.
//    slave  : the sequencer side (samples pwr_req/pwr_good, drives controls)
//    master : the requester / power-switch model side
interface altr_hps_pd_seq_if;
   logic pwr_req;
   logic pwr_good;
   logic pwr_sw_en;
   logic clk_en;
   logic dom_rst_n;
   logic iso_en;
   logic pwr_ack;
   logic busy;
   logic err;

   modport slave (
      input  pwr_req, pwr_good,
      output pwr_sw_en, clk_en, dom_rst_n, iso_en, pwr_ack, busy, err
   );

   modport master (
      output pwr_req, pwr_good,
      input  pwr_sw_en, clk_en, dom_rst_n, iso_en, pwr_ack, busy, err
   );
endinterface

// File: rtl/altr_hps_pd_seq_cnt.sv
// 8-bit dwell/timeout counter for the power-domain sequencer.
//    clk, rst_n : clock, asynchronous active-low reset
//    clr        : restart from zero (asserted on every state change)
//    en         : count enable
//    tc_val     : terminal-count value
//    tc         : high while the count equals tc_val
module altr_hps_pd_seq_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] tc_val,
   output logic       tc
);

   logic [7:0] cnt_q;

   // Count up from zero after each clear and stick at all-ones, so a
   // state that is held for a long time can never wrap and alias a
   // small terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != 8'hFF)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/altr_hps_pd_seq.sv
// Power-domain on/off sequencer.
//    Parameters : STEP_CYC dwell between steps, TMO_CYC pwr_good wait limit
//    clk, rst_n : clock, asynchronous active-low reset
//    bus        : pwr_req/pwr_good in; pwr_sw_en, clk_en, dom_rst_n, iso_en,
//                 pwr_ack, busy, err out (all registered)
module altr_hps_pd_seq
   import altr_hps_pd_seq_pkg::*;
#(
   parameter int STEP_CYC = 4,
   parameter int TMO_CYC  = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   altr_hps_pd_seq_if.slave bus
);

   // A terminal count of N-1 makes the transition fall on the Nth edge
   // after the state was entered, because the counter reads 0 after entry.
   localparam logic [7:0] STEP_TC = 8'(STEP_CYC - 1);
   localparam logic [7:0] TMO_TC  = 8'(TMO_CYC - 1);

   state_t     state_q, state_nxt;
   logic       err_q, err_nxt;
   outs_t      outs_q;
   logic       cnt_tc;
   logic       cnt_clr;
   logic       cnt_en;
   logic [7:0] cnt_tc_val;

   assign cnt_clr    = (state_nxt != state_q);
   assign cnt_en     = (state_q != OFF) && (state_q != ON);
   assign cnt_tc_val = is_timeout_wait(state_q) ? TMO_TC : STEP_TC;

   altr_hps_pd_seq_cnt u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .tc_val (cnt_tc_val),
      .tc     (cnt_tc)
   );

   // State, sticky error and the decoded outputs all update together so
   // every output is a flop and changes on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OFF;
         err_q   <= 1'b0;
         outs_q  <= OFF_OUTS;
      end else begin
         state_q <= state_nxt;
         err_q   <= err_nxt;
         outs_q  <= decode_outs(state_nxt);
      end
   end

   // Requests are only looked at in OFF and ON, so a started sequence
   // always runs to completion. pwr_good only matters in the two states
   // that wait on the rail; if it never arrives the sequencer gives up,
   // flags err and falls back to OFF, where err blocks new power-ups
   // until the requester drops pwr_req.
   always_comb begin
      state_nxt = state_q;
      err_nxt   = err_q;
      case (state_q)
         OFF: begin
            if (err_q) begin
               if (!bus.pwr_req) err_nxt = 1'b0;
            end else if (bus.pwr_req) begin
               state_nxt = PWR_UP;
            end
         end
         PWR_UP: begin
            if (bus.pwr_good) begin
               state_nxt = CLK_ON;
            end else if (cnt_tc) begin
               state_nxt = OFF;
               err_nxt   = 1'b1;
            end
         end
         CLK_ON:  if (cnt_tc) state_nxt = RST_REL;
         RST_REL: if (cnt_tc) state_nxt = ISO_REL;
         ISO_REL: if (cnt_tc) state_nxt = ON;
         ON:      if (!bus.pwr_req) state_nxt = ISO_SET;
         ISO_SET: if (cnt_tc) state_nxt = RST_SET;
         RST_SET: if (cnt_tc) state_nxt = CLK_OFF;
         CLK_OFF: if (cnt_tc) state_nxt = PWR_DN;
         PWR_DN: begin
            if (!bus.pwr_good) begin
               state_nxt = OFF;
            end else if (cnt_tc) begin
               state_nxt = OFF;
               err_nxt   = 1'b1;
            end
         end
         default: state_nxt = OFF;
      endcase
   end

   assign bus.pwr_sw_en = outs_q.pwr_sw_en;
   assign bus.clk_en    = outs_q.clk_en;
   assign bus.dom_rst_n = outs_q.dom_rst_n;
   assign bus.iso_en    = outs_q.iso_en;
   assign bus.pwr_ack   = outs_q.pwr_ack;
   assign bus.busy      = outs_q.busy;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_altr_hps_pd_seq.sv
// Directed testbench for altr_hps_pd_seq (STEP_CYC=4, TMO_CYC=16).
// Output vectors are packed {pwr_sw_en, clk_en, dom_rst_n, iso_en, pwr_ack, busy, err}.
module tb_altr_hps_pd_seq;

   localparam logic [6:0] V_OFF     = 7'b0001000;
   localparam logic [6:0] V_OFF_ERR = 7'b0001001;
   localparam logic [6:0] V_PWR_UP  = 7'b1001010;
   localparam logic [6:0] V_CLK_ON  = 7'b1101010;
   localparam logic [6:0] V_RST_REL = 7'b1111010;
   localparam logic [6:0] V_ISO_REL = 7'b1110010;
   localparam logic [6:0] V_ON      = 7'b1110100;
   localparam logic [6:0] V_ISO_SET = 7'b1111010;
   localparam logic [6:0] V_RST_SET = 7'b1101010;
   localparam logic [6:0] V_CLK_OFF = 7'b1001010;
   localparam logic [6:0] V_PWR_DN  = 7'b0001010;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   altr_hps_pd_seq_if bus_if ();

   altr_hps_pd_seq #(
      .STEP_CYC (4),
      .TMO_CYC  (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and land 1 time unit after the last one, where
   // both new inputs are driven and outputs are sampled.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic req, input logic good);
      bus_if.pwr_req  = req;
      bus_if.pwr_good = good;
   endtask

   task automatic checkOutput(input string tag, input logic [6:0] expv);
      logic [6:0] obs;
      obs = {bus_if.pwr_sw_en, bus_if.clk_en, bus_if.dom_rst_n, bus_if.iso_en,
             bus_if.pwr_ack, bus_if.busy, bus_if.err};
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 checkOutput("reset_async", V_OFF);
      tick(2);
      checkOutput("reset_held", V_OFF);
      rst_n = 1'b1;
      tick(2);
      checkOutput("idle_off", V_OFF);

      $display("[TB] power-up sequence");
      applyStimulus(1'b1, 1'b0);
      tick(1);
      checkOutput("up_pwr_up", V_PWR_UP);
      tick(1);
      checkOutput("up_wait_good", V_PWR_UP);
      applyStimulus(1'b1, 1'b1);
      tick(1);
      checkOutput("up_clk_on_k", V_CLK_ON);
      tick(3);
      checkOutput("up_clk_on_k3", V_CLK_ON);
      tick(1);
      checkOutput("up_rst_rel_k4", V_RST_REL);
      tick(3);
      checkOutput("up_rst_rel_k7", V_RST_REL);
      tick(1);
      checkOutput("up_iso_rel_k8", V_ISO_REL);
      tick(3);
      checkOutput("up_iso_rel_k11", V_ISO_REL);
      tick(1);
      checkOutput("up_on_k12", V_ON);

      applyStimulus(1'b1, 1'b0);
      tick(2);
      checkOutput("on_ignores_good", V_ON);
      applyStimulus(1'b1, 1'b1);

      $display("[TB] power-down sequence");
      applyStimulus(1'b0, 1'b1);
      tick(1);
      checkOutput("dn_iso_set_m", V_ISO_SET);
      tick(4);
      checkOutput("dn_rst_set_m4", V_RST_SET);
      tick(4);
      checkOutput("dn_clk_off_m8", V_CLK_OFF);
      tick(3);
      checkOutput("dn_clk_off_m11", V_CLK_OFF);
      tick(1);
      checkOutput("dn_pwr_dn_m12", V_PWR_DN);
      tick(2);
      checkOutput("dn_wait_good", V_PWR_DN);
      applyStimulus(1'b0, 1'b0);
      tick(1);
      checkOutput("dn_off", V_OFF);

      $display("[TB] power-up timeout");
      applyStimulus(1'b1, 1'b0);
      tick(1);
      checkOutput("tmo_pwr_up", V_PWR_UP);
      tick(15);
      checkOutput("tmo_before", V_PWR_UP);
      tick(1);
      checkOutput("tmo_err", V_OFF_ERR);
      tick(3);
      checkOutput("tmo_req_ignored", V_OFF_ERR);
      applyStimulus(1'b0, 1'b0);
      tick(1);
      checkOutput("tmo_err_clear", V_OFF);

      $display("[TB] request dropped mid power-up");
      applyStimulus(1'b1, 1'b1);
      tick(1);
      checkOutput("mid_pwr_up", V_PWR_UP);
      tick(1);
      checkOutput("mid_clk_on", V_CLK_ON);
      applyStimulus(1'b0, 1'b1);
      tick(4);
      checkOutput("mid_rst_rel", V_RST_REL);
      tick(4);
      checkOutput("mid_iso_rel", V_ISO_REL);
      tick(4);
      checkOutput("mid_on", V_ON);
      tick(1);
      checkOutput("mid_iso_set", V_ISO_SET);
      tick(12);
      checkOutput("mid_pwr_dn", V_PWR_DN);
      applyStimulus(1'b0, 1'b0);
      tick(1);
      checkOutput("mid_off", V_OFF);

      $display("[TB] reset during RST_REL");
      applyStimulus(1'b1, 1'b1);
      tick(1);
      checkOutput("rst_pwr_up", V_PWR_UP);
      tick(1);
      checkOutput("rst_clk_on", V_CLK_ON);
      tick(4);
      checkOutput("rst_rst_rel", V_RST_REL);
      #2 rst_n = 1'b0;
      #1 checkOutput("rst_async_mid", V_OFF);
      tick(2);
      checkOutput("rst_held_mid", V_OFF);
      rst_n = 1'b1;
      tick(1);
      checkOutput("rst_restart_up", V_PWR_UP);
      tick(1);
      checkOutput("rst_restart_clk", V_CLK_ON);
      tick(12);
      checkOutput("rst_restart_on", V_ON);

      $display("[TB] power-down timeout");
      applyStimulus(1'b0, 1'b1);
      tick(1);
      checkOutput("dtmo_iso_set", V_ISO_SET);
      tick(12);
      checkOutput("dtmo_pwr_dn", V_PWR_DN);
      tick(15);
      checkOutput("dtmo_before", V_PWR_DN);
      tick(1);
      checkOutput("dtmo_err", V_OFF_ERR);
      tick(1);
      checkOutput("dtmo_err_clear", V_OFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/altr_hps_pd_seq.md
ALTR_HPS_PD_SEQ -- requirements
Module: altr_hps_pd_seq

Interface
REQ-001 SHALL have parameter STEP_CYC, default 4, dwell cycles between consecutive sequence steps (legal 1..255).
REQ-002 SHALL have parameter TMO_CYC, default 255, maximum cycles to wait for pwr_good to change (legal 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all other inputs are synchronous to clk.
REQ-004 SHALL have port clk  input  1  block clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pwr_req  input  1  1 = request domain powered, 0 = request domain off.
REQ-007 SHALL have port pwr_good  input  1  power-switch status from domain, 1 = rail up.
REQ-008 SHALL have port pwr_sw_en  output  1  power-switch enable.
REQ-009 SHALL have port clk_en  output  1  domain clock-gate enable.
REQ-010 SHALL have port dom_rst_n  output  1  domain reset, active low.
REQ-011 SHALL have port iso_en  output  1  NOR-clamp isolation enable, 1 = domain outputs clamped to 0.
REQ-012 SHALL have port pwr_ack  output  1  1 = domain fully on and unisolated.
REQ-013 SHALL have port busy  output  1  1 = sequence in progress.
REQ-014 SHALL have port err  output  1  sticky pwr_good timeout flag.

Function
REQ-015 SHALL implement states OFF, PWR_UP, CLK_ON, RST_REL, ISO_REL, ON, ISO_SET, RST_SET, CLK_OFF, PWR_DN.
REQ-016 All outputs SHALL be registered, decoded from state, no combinational input-to-output path.
REQ-017 OFF with pwr_req=1 and err=0 at edge n SHALL enter PWR_UP: pwr_sw_en=1, busy=1 after edge n.
REQ-018 PWR_UP sampling pwr_good=1 at edge k SHALL give clk_en=1 after k, dom_rst_n=1 after k+STEP_CYC, iso_en=0 after k+2*STEP_CYC, pwr_ack=1 and busy=0 after k+3*STEP_CYC (state ON).
REQ-019 ON sampling pwr_req=0 at edge m SHALL give pwr_ack=0, iso_en=1, busy=1 after m; dom_rst_n=0 after m+STEP_CYC; clk_en=0 after m+2*STEP_CYC; pwr_sw_en=0 after m+3*STEP_CYC (state PWR_DN).
REQ-020 PWR_DN sampling pwr_good=0 SHALL enter OFF with busy=0 on that edge.
REQ-021 A sequence in progress SHALL complete; pwr_req changes mid-sequence are evaluated only in OFF and ON.
REQ-022 PWR_UP not seeing pwr_good=1 within TMO_CYC cycles SHALL set err=1, drive pwr_sw_en=0, enter OFF; clk_en, dom_rst_n, iso_en remain at off values.
REQ-023 PWR_DN not seeing pwr_good=0 within TMO_CYC cycles SHALL set err=1 and enter OFF.
REQ-024 err SHALL clear only when OFF samples pwr_req=0; while err=1 pwr_req=1 SHALL be ignored.
REQ-025 pwr_good changes outside PWR_UP/PWR_DN SHALL be ignored.
REQ-026 Dwell/timeout counter SHALL be 8 bits, cleared on every state entry, never wrap (saturate).

Reset
REQ-027 rst_n low SHALL asynchronously force OFF: pwr_sw_en=0, clk_en=0, dom_rst_n=0, iso_en=1, pwr_ack=0, busy=0, err=0, counter=0.
REQ-028 Reset mid-sequence SHALL apply REQ-027 immediately; release SHALL be synchronous to clk, first transition no earlier than the first edge after deassertion.

Structure
REQ-029 State encoding enum and off-value output constants SHALL live in package altr_hps_pd_seq_pkg.
REQ-030 Dwell/timeout counter SHALL be sub-module altr_hps_pd_seq_cnt (load-clear, enable, saturate, terminal-count compare).

Verification
REQ-031 Reset check: rst_n=0 -> iso_en=1, dom_rst_n=0, all other outputs 0.
REQ-032 Power-up, STEP_CYC=4: pwr_req=1, pwr_good=1 two cycles after pwr_sw_en -> clk_en, dom_rst_n, iso_en fall, pwr_ack at k, k+4, k+8, k+12.
REQ-033 Power-down from ON: pwr_req=0 -> iso_en=1 at m, dom_rst_n=0 at m+4, clk_en=0 at m+8, pwr_sw_en=0 at m+12; pwr_good=0 -> busy=0.
REQ-034 Timeout, TMO_CYC=16: pwr_good held 0 -> err=1, pwr_sw_en=0 after 16 cycles; pwr_req=1 ignored; pwr_req=0 clears err.
REQ-035 pwr_req toggled 0 during CLK_ON -> up sequence completes to pwr_ack=1, then down sequence starts.
REQ-036 rst_n asserted in RST_REL -> outputs reach reset values asynchronously; after release, pwr_req=1 restarts from PWR_UP.
